// File: rtl/ysyx_23060042_pkg.sv
// Shared constants and types for the ysyx_23060042 instruction fetch slice.
package ysyx_23060042_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_W   = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h8000_0000;

  typedef enum logic [1:0] {
    BOOT,
    REQ,
    WAIT,
    HOLD
  } ifu_state_e;

  // Fetch addresses are always word aligned; low two bits are forced to zero.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
    return a & ~PC_W'(3);
  endfunction

endpackage

// File: rtl/ysyx_23060042_ifu_perf.sv
// Fetch performance counters: delivered instructions and cycles spent waiting on memory.
module ysyx_23060042_ifu_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_fire,
  input  logic        in_wait,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_wait_cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_wait_cnt  <= '0;
    end else begin
      if (inst_fire) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      if (in_wait)   perf_wait_cnt  <= perf_wait_cnt + 64'd1;
    end
  end

endmodule

// File: rtl/ysyx_23060042_ifu.sv
// Multi-cycle instruction fetch unit: one word read per instruction, redirectable PC.
// Optional counters enabled by defining YSYX_23060042_IFU_PERF_EN.
module ysyx_23060042_ifu
  import ysyx_23060042_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [PC_W-1:0]   mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [INST_W-1:0] mem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc
`ifdef YSYX_23060042_IFU_PERF_EN
  ,
  output logic [63:0]       perf_fetch_cnt,
  output logic [63:0]       perf_wait_cnt
`endif
);

  ifu_state_e      state;
  logic [PC_W-1:0] pc;
  logic            squash;

  assign mem_req_valid = (state == REQ);
  assign mem_req_addr  = mem_req_valid ? pc : '0;
  assign inst_valid    = (state == HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= BOOT;
      pc      <= RESET_PC;
      squash  <= 1'b0;
      inst    <= '0;
      inst_pc <= '0;
    end else begin
      case (state)
        BOOT: state <= REQ;
        REQ: begin
          if (redirect_valid) pc <= word_align(redirect_pc);
          // A request accepted alongside a redirect is for the stale PC; drop its reply.
          if (mem_req_ready) begin
            state  <= WAIT;
            squash <= redirect_valid;
          end
        end
        WAIT: begin
          if (redirect_valid) pc <= word_align(redirect_pc);
          if (mem_rsp_valid) begin
            if (!squash && !redirect_valid) begin
              inst    <= mem_rsp_data;
              inst_pc <= pc;
              state   <= HOLD;
            end else begin
              squash <= 1'b0;
              state  <= REQ;
            end
          end else if (redirect_valid) begin
            squash <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc    <= word_align(redirect_pc);
            state <= REQ;
          end else if (inst_ready) begin
            pc    <= pc + PC_W'(4);
            state <= REQ;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef YSYX_23060042_IFU_PERF_EN
  ysyx_23060042_ifu_perf u_perf (
    .clk            (clk),
    .rst            (rst),
    .inst_fire      (inst_valid & inst_ready),
    .in_wait        (state == WAIT),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_wait_cnt  (perf_wait_cnt)
  );
`endif

`ifndef SYNTHESIS
  rsp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
    mem_rsp_valid |-> (state == WAIT || state == BOOT));
`endif

endmodule

// File: tb/tb_ysyx_23060042_ifu.sv
// Scoreboard bench for ysyx_23060042_ifu: directed fetch sequences against a small memory model.
module tb_ysyx_23060042_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef YSYX_23060042_IFU_PERF_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_wait_cnt;
`endif

  always #5 clk = ~clk;

  ysyx_23060042_ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
`ifdef YSYX_23060042_IFU_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_wait_cnt  (perf_wait_cnt)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } inst_t;

  int          checks = 0;
  int          passes = 0;
  logic [31:0] exp_addr_q[$];
  inst_t       exp_inst_q[$];

  // memory model state
  int          grants = 0;
  int          stall_cnt = 0;
  int          lat = 1;
  bit          pend = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  bit          rec_valid = 0;
  bit          rec_ready = 0;
  logic [31:0] rec_addr = '0;
  bit          fired = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h8000_0000: return 32'h0000_0013;
      32'h8000_000C: return 32'hDEAD_BEEF;
      default:       return a ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic push_fetch(input logic [31:0] a);
    inst_t e;
    e.pc   = a;
    e.data = mem_word(a);
    exp_addr_q.push_back(a);
    exp_inst_q.push_back(e);
  endtask

  // One cycle: act on the handshake seen at the previous negedge, then drive memory inputs.
  task automatic tick();
    @(negedge clk);
    fired = rec_valid && rec_ready;
    if (fired) begin
      pend      = 1;
      pend_cnt  = lat - 1;
      pend_addr = rec_addr;
      if (grants > 0) grants--;
    end else if (pend && pend_cnt > 0) begin
      pend_cnt--;
    end
    if (pend && pend_cnt == 0) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(pend_addr);
      pend          = 0;
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
    mem_req_ready = (grants > 0) && (stall_cnt == 0);
    if (stall_cnt > 0) stall_cnt--;
    rec_valid = mem_req_valid;
    rec_ready = mem_req_ready;
    rec_addr  = mem_req_addr;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((exp_addr_q.size() != 0 || exp_inst_q.size() != 0) && n < max) begin
      tick();
      n++;
    end
    if (exp_addr_q.size() != 0 || exp_inst_q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d req / %0d inst outstanding, expected 0",
               exp_addr_q.size(), exp_inst_q.size());
      exp_addr_q.delete();
      exp_inst_q.delete();
    end
  endtask

  task automatic wait_fire(input int max);
    int n = 0;
    fired = 0;
    while (!fired && n < max) begin
      tick();
      n++;
    end
    if (!fired) begin
      checks++;
      $display("FAIL fire_timeout: no request accepted in %0d cycles, expected one", max);
    end
  endtask

  task automatic wait_inst(input int max);
    int n = 0;
    while (!inst_valid && n < max) begin
      tick();
      n++;
    end
    chk("inst_valid_timeout", 64'(inst_valid), 64'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req_valid"}, 64'(mem_req_valid), 64'd0);
    chk({tag, "_req_addr"},  64'(mem_req_addr),  64'd0);
    chk({tag, "_inst_valid"}, 64'(inst_valid),   64'd0);
    chk({tag, "_inst"},      64'(inst),          64'd0);
    chk({tag, "_inst_pc"},   64'(inst_pc),       64'd0);
`ifdef YSYX_23060042_IFU_PERF_EN
    chk({tag, "_perf_fetch"}, perf_fetch_cnt, 64'd0);
    chk({tag, "_perf_wait"},  perf_wait_cnt,  64'd0);
`endif
  endtask

  // Monitor: compares presented requests/instructions against the scoreboard fronts.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (inst_valid) begin
          chk("no_req_in_hold", 64'(mem_req_valid), 64'd0);
          if (exp_inst_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_inst: got pc %h inst %h, expected none", inst_pc, inst);
          end else begin
            chk("inst",    64'(inst),    64'(exp_inst_q[0].data));
            chk("inst_pc", 64'(inst_pc), 64'(exp_inst_q[0].pc));
            if (inst_ready) void'(exp_inst_q.pop_front());
          end
        end
        if (mem_req_valid) begin
          if (exp_addr_q.size() != 0) begin
            chk("req_addr", 64'(mem_req_addr), 64'(exp_addr_q[0]));
            if (mem_req_ready) void'(exp_addr_q.pop_front());
          end else if (mem_req_ready) begin
            checks++;
            $display("FAIL unexpected_req: got addr %h accepted, expected none", mem_req_addr);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_req_ready  = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = '0;
    inst_ready     = 1'b0;
    repeat (3) tick();
    check_reset("reset");
    rst = 1'b0;

    // Back-to-back fetches, 1-cycle memory latency
    inst_ready = 1'b1;
    push_fetch(32'h8000_0000);
    push_fetch(32'h8000_0004);
    grants = 2;
    drain(40);

    // Decoder stalls for 5 cycles in HOLD
    inst_ready = 1'b0;
    push_fetch(32'h8000_0008);
    grants = 1;
    wait_inst(40);
    repeat (5) tick();
    inst_ready = 1'b1;
    drain(20);

    // Redirect during WAIT; the late response must be dropped
    lat = 2;
    exp_addr_q.push_back(32'h8000_000C);
    grants = 1;
    wait_fire(40);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_1003;
    tick();
    redirect_valid = 1'b0;
    lat = 1;
    push_fetch(32'h8000_1000);
    grants = 1;
    drain(40);

    // Redirect in HOLD together with the decoder handshake
    inst_ready = 1'b0;
    push_fetch(32'h8000_1004);
    grants = 1;
    wait_inst(40);
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    push_fetch(32'h8000_0100);
    grants = 1;
    drain(40);

    // Redirect in REQ to the top word, wrap to 0, then memory stall
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    push_fetch(32'hFFFF_FFFC);
    grants = 1;
    drain(40);
    push_fetch(32'h0000_0000);
    stall_cnt = 3;
    grants    = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_req_valid", 64'(mem_req_valid), 64'd1);
    end
    drain(20);

    // Reset while a request is outstanding; its response lands during reset
    lat = 2;
    exp_addr_q.push_back(32'h0000_0004);
    grants = 1;
    wait_fire(40);
    rst = 1'b1;
    repeat (3) tick();
    check_reset("reset_mid");
    rst = 1'b0;

    // Ten fetches with 2-cycle memory latency
    inst_ready = 1'b1;
    for (int i = 0; i < 10; i++) push_fetch(32'h8000_0000 + 32'(4 * i));
    grants = 10;
    drain(200);
`ifdef YSYX_23060042_IFU_PERF_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, 64'd10);
    chk("perf_wait_cnt",  perf_wait_cnt,  64'd20);
`endif

    repeat (2) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
